// File: rtl/jk_q_monitor_if.sv
// Bundle between a q-source test harness and the jk_q_monitor checker.
// The harness drives enable/clear/q; the monitor returns edge pulses and statistics.
interface jk_q_monitor_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             clr;
  logic             q_in;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] toggle_cnt;
  logic [CNT_W-1:0] last_high_len;
  logic             stuck;
  logic [1:0]       state_o;

  modport master (
    output en, clr, q_in,
    input  rise, fall, toggle_cnt, last_high_len, stuck, state_o
  );

  modport slave (
    input  en, clr, q_in,
    output rise, fall, toggle_cnt, last_high_len, stuck, state_o
  );
endinterface

// File: rtl/jk_q_monitor.sv
// Edge, toggle, high-pulse-length and stuck-level monitor for the jk_ff q output.
// state | meaning: INIT no sample yet | LOW q low | HIGH q high | STUCK q held TIMEOUT+ samples
module jk_q_monitor #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rstn,
  jk_q_monitor_if.slave    bus
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_LOW   = 2'd1,
    S_HIGH  = 2'd2,
    S_STUCK = 2'd3
  } state_t;

  state_t           state;
  logic             level;
  logic [CNT_W-1:0] run_len;
  logic [CNT_W-1:0] run_inc;
  logic [CNT_W-1:0] toggle_cnt;
  logic [CNT_W-1:0] last_high_len;
  logic             rise;
  logic             fall;
  logic             stuck;

  assign run_inc = run_len + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rstn || bus.clr) begin
      state         <= S_INIT;
      level         <= 1'b0;
      run_len       <= '0;
      toggle_cnt    <= '0;
      last_high_len <= '0;
      rise          <= 1'b0;
      fall          <= 1'b0;
      stuck         <= 1'b0;
    end else if (!bus.en) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (state == S_INIT) begin
        level   <= bus.q_in;
        run_len <= CNT_W'(1);
        state   <= bus.q_in ? S_HIGH : S_LOW;
      end else if (bus.q_in != level) begin
        // Same action from LOW/HIGH and from STUCK; direction follows the held level.
        toggle_cnt <= toggle_cnt + CNT_W'(1);
        level      <= bus.q_in;
        run_len    <= CNT_W'(1);
        stuck      <= 1'b0;
        if (level) begin
          fall          <= 1'b1;
          last_high_len <= run_len;
          state         <= S_LOW;
        end else begin
          rise  <= 1'b1;
          state <= S_HIGH;
        end
      end else if (state == S_STUCK) begin
        if (run_len != '1) run_len <= run_inc;
      end else begin
        run_len <= run_inc;
        if (run_inc == CNT_W'(TIMEOUT)) begin
          state <= S_STUCK;
          stuck <= 1'b1;
        end
      end
    end
  end

  assign bus.rise          = rise;
  assign bus.fall          = fall;
  assign bus.toggle_cnt    = toggle_cnt;
  assign bus.last_high_len = last_high_len;
  assign bus.stuck         = stuck;
  assign bus.state_o       = state;

endmodule

// File: tb/tb_jk_q_monitor.sv
// Self-checking bench for jk_q_monitor: hand-derived vector table plus a
// scoreboard fed by a behavioural model, with spot checks on the corner cases.
module tb_jk_q_monitor;

  typedef struct packed {
    logic [1:0] st;
    logic       rise;
    logic       fall;
    logic [7:0] cnt;
    logic [7:0] hl;
    logic       stuck;
  } obs_t;

  typedef struct {
    logic r;
    logic e;
    logic c;
    logic q;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  obs_t exp_q[$];
  vec_t vecs[8];

  // Reference model state
  int       m_state;
  logic     m_level;
  int       m_run;
  logic [7:0] m_cnt;
  logic [7:0] m_hl;
  logic     m_rise;
  logic     m_fall;
  logic     m_stuck;

  jk_q_monitor_if #(.CNT_W(8)) bus ();

  jk_q_monitor #(.CNT_W(8), .TIMEOUT(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t actual();
    obs_t a;
    a.st    = bus.state_o;
    a.rise  = bus.rise;
    a.fall  = bus.fall;
    a.cnt   = bus.toggle_cnt;
    a.hl    = bus.last_high_len;
    a.stuck = bus.stuck;
    return a;
  endfunction

  function automatic vec_t mkv(logic r, logic e, logic c, logic q, logic [1:0] st,
                               logic ri, logic fa, logic [7:0] cnt, logic [7:0] hl, logic sk);
    vec_t v;
    v.r = r; v.e = e; v.c = c; v.q = q;
    v.exp.st = st; v.exp.rise = ri; v.exp.fall = fa;
    v.exp.cnt = cnt; v.exp.hl = hl; v.exp.stuck = sk;
    return v;
  endfunction

  task automatic model(input logic r, input logic e, input logic c, input logic q);
    if (r || c) begin
      m_state = 0; m_level = 1'b0; m_run = 0; m_cnt = 8'd0; m_hl = 8'd0;
      m_rise = 1'b0; m_fall = 1'b0; m_stuck = 1'b0;
    end else if (!e) begin
      m_rise = 1'b0; m_fall = 1'b0;
    end else begin
      m_rise = 1'b0; m_fall = 1'b0;
      if (m_state == 0) begin
        m_level = q; m_run = 1; m_state = q ? 2 : 1;
      end else if (q != m_level) begin
        m_cnt = m_cnt + 8'd1;
        if (m_level) begin
          m_fall = 1'b1; m_hl = 8'(m_run); m_state = 1;
        end else begin
          m_rise = 1'b1; m_state = 2;
        end
        m_level = q; m_run = 1; m_stuck = 1'b0;
      end else begin
        if (m_run < 255) m_run = m_run + 1;
        if (m_state != 3 && m_run == 16) begin
          m_state = 3; m_stuck = 1'b1;
        end
      end
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.st = 2'(m_state); o.rise = m_rise; o.fall = m_fall;
    o.cnt = m_cnt; o.hl = m_hl; o.stuck = m_stuck;
    return o;
  endfunction

  task automatic step(input logic r, input logic e, input logic c, input logic q);
    obs_t ex;
    obs_t a;
    @(negedge clk);
    rstn = r; bus.en = e; bus.clr = c; bus.q_in = q;
    model(r, e, c, q);
    exp_q.push_back(model_obs());
    @(posedge clk);
    #1;
    cyc++;
    checks++;
    a = actual();
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty cyc=%0d actual=%h required=entry", cyc, a);
    end else begin
      ex = exp_q.pop_front();
      if (a !== ex)  begin
        failures++;
        $display("FAIL scoreboard cyc=%0d actual=%h required=%h", cyc, a, ex);
      end
    end
  endtask

  task automatic spot(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  initial begin
    obs_t a;
    bus.en = 1'b0; bus.clr = 1'b0; bus.q_in = 1'b0;

    // r e c q | st ri fa cnt hl stuck  (reset, then 0,0,1,1,1,0)
    vecs[0] = mkv(1, 0, 0, 0, 2'd0, 0, 0, 8'd0, 8'd0, 0);
    vecs[1] = mkv(1, 0, 0, 0, 2'd0, 0, 0, 8'd0, 8'd0, 0);
    vecs[2] = mkv(0, 1, 0, 0, 2'd1, 0, 0, 8'd0, 8'd0, 0);
    vecs[3] = mkv(0, 1, 0, 0, 2'd1, 0, 0, 8'd0, 8'd0, 0);
    vecs[4] = mkv(0, 1, 0, 1, 2'd2, 1, 0, 8'd1, 8'd0, 0);
    vecs[5] = mkv(0, 1, 0, 1, 2'd2, 0, 0, 8'd1, 8'd0, 0);
    vecs[6] = mkv(0, 1, 0, 1, 2'd2, 0, 0, 8'd1, 8'd0, 0);
    vecs[7] = mkv(0, 1, 0, 0, 2'd1, 0, 1, 8'd2, 8'd3, 0);

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].r, vecs[i].e, vecs[i].c, vecs[i].q);
      a = actual();
      checks++;
      if (a !== vecs[i].exp) begin
        failures++;
        $display("FAIL vector_%0d actual=%h required=%h", i, a, vecs[i].exp);
      end
    end

    // Stuck threshold: entry sample counts as 1, stuck on the 16th.
    step(0, 1, 0, 1);
    for (int i = 0; i < 14; i++) step(0, 1, 0, 1);
    spot("stuck_not_at_15", int'(bus.stuck), 0);
    spot("state_at_15", int'(bus.state_o), 2);
    step(0, 1, 0, 1);
    spot("stuck_at_16", int'(bus.stuck), 1);
    spot("state_at_16", int'(bus.state_o), 3);
    step(0, 1, 0, 0);
    spot("stuck_exit_fall", int'(bus.fall), 1);
    spot("stuck_exit_clear", int'(bus.stuck), 0);
    spot("stuck_exit_hl", int'(bus.last_high_len), 16);
    spot("stuck_exit_state", int'(bus.state_o), 1);

    // 257 toggles from a fresh LOW: count wraps to 1, pulses alternate.
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 257; i++) begin
      step(0, 1, 0, (i % 2 == 0) ? 1'b1 : 1'b0);
      spot("toggle_pulse", int'(bus.rise ^ bus.fall), 1);
    end
    spot("toggle_wrap_cnt", int'(bus.toggle_cnt), 1);
    spot("toggle_no_stuck", int'(bus.stuck), 0);

    // Frozen while en=0; the run resumes from 5 afterwards.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, (i < 5) ? 1'b0 : 1'b1);
    spot("freeze_cnt", int'(bus.toggle_cnt), 1);
    spot("freeze_state", int'(bus.state_o), 2);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 1);
    spot("resume_not_stuck", int'(bus.state_o), 2);
    step(0, 1, 0, 1);
    spot("resume_stuck", int'(bus.state_o), 3);

    // Run-length saturation in STUCK shows up in last_high_len.
    for (int i = 0; i < 280; i++) step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    spot("saturated_hl", int'(bus.last_high_len), 255);

    // clr mid high pulse with toggle_cnt=7; toggle on the clr edge is ignored.
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, (i % 2 == 0) ? 1'b1 : 1'b0);
    step(0, 1, 0, 1);
    spot("pre_clr_cnt", int'(bus.toggle_cnt), 7);
    spot("pre_clr_hl", int'(bus.last_high_len), 1);
    step(0, 1, 1, 0);
    spot("clr_cnt", int'(bus.toggle_cnt), 0);
    spot("clr_hl", int'(bus.last_high_len), 0);
    spot("clr_state", int'(bus.state_o), 0);
    step(0, 1, 0, 1);
    spot("reentry_state", int'(bus.state_o), 2);
    spot("reentry_no_rise", int'(bus.rise), 0);
    spot("reentry_cnt", int'(bus.toggle_cnt), 0);

    // clr outranks en=0, and rise clears on a disabled cycle.
    step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    step(0, 0, 0, 0);
    spot("disabled_rise_clear", int'(bus.rise), 0);
    step(0, 0, 1, 1);
    spot("clr_over_en", int'(bus.toggle_cnt), 0);
    step(1, 1, 0, 1);
    spot("rst_state", int'(bus.state_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jk_q_monitor.md
Name: jk_q_monitor

Overview:
- Downstream consumer of the jk_ff output `q`.
- Samples `q` every enabled cycle and reports rising and falling edges as single-cycle pulses.
- Counts toggles, measures the length of the most recent high pulse, and flags a stuck output when `q` holds one level for too long.
- Used as an on-chip checker alongside the JK flip-flop stage and in its test benches.

Parameters:
- CNT_W, 8: width of toggle_cnt, last_high_len and the internal run-length counter.
- TIMEOUT, 16: consecutive same-level samples that trigger stuck; legal range 2 to 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rstn  input  1  synchronous, active-high reset (1 = reset).
- en  input  1  sample enable; when 0, all state is frozen.
- clr  input  1  synchronous soft clear of statistics and FSM.
- q_in  input  1  q from jk_ff; same clock domain, no synchronizer.
- rise  output  1  one-cycle pulse on a 0->1 transition.
- fall  output  1  one-cycle pulse on a 1->0 transition.
- toggle_cnt  output  CNT_W  number of transitions since reset/clr; wraps.
- last_high_len  output  CNT_W  length in samples of the last completed high pulse.
- stuck  output  1  q_in has held one level for TIMEOUT or more samples.
- state_o  output  2  FSM state: 0 INIT, 1 LOW, 2 HIGH, 3 STUCK.

Behaviour:
- Outputs are registered; an event sampled at edge t is visible right after edge t.
- Priority: rstn > clr > en=0 > normal operation.
- Reset (rstn=1 at an edge): state=INIT, rise=0, fall=0, toggle_cnt=0, last_high_len=0, stuck=0, run_len=0, level=0.
- clr=1: same as reset. Reset or clr mid-pulse discards the run in progress.
- en=0: rise=0 and fall=0 next cycle; every other register holds its value. No sample is taken.
- rise and fall are 0 on every edge unless set by a transition below. They are never both 1.
- INIT, first enabled sample:
  - level <= q_in, run_len <= 1.
  - Go to LOW if q_in=0, HIGH if q_in=1.
  - No edge pulse, no count.
- LOW, q_in=1: rise<=1, toggle_cnt+1, level<=1, run_len<=1, go to HIGH.
- HIGH, q_in=0: fall<=1, toggle_cnt+1, last_high_len<=run_len, level<=0, run_len<=1, go to LOW.
- LOW or HIGH, q_in unchanged:
  - run_len increments.
  - If the incremented value equals TIMEOUT: state<=STUCK, stuck<=1.
  - stuck therefore asserts at the edge of the TIMEOUT-th consecutive same-level sample, counting the entry sample as 1.
- STUCK, q_in unchanged: run_len increments, saturating at 2^CNT_W-1.
- STUCK, q_in != level:
  - Same actions as the LOW/HIGH transition for that direction, including the last_high_len update when level was 1.
  - stuck<=0; next state LOW or HIGH.
- toggle_cnt wraps from 2^CNT_W-1 to 0 (modular). run_len saturates and never wraps.
- A toggle in the same cycle as clr or rstn is ignored.

Test Plan (CNT_W=8, TIMEOUT=16):
1. rstn=1 for 2 cycles, then rstn=0, en=1, q_in=0 -> after the first edge state_o=1, rise=fall=0, toggle_cnt=0, stuck=0.
2. q_in sequence 0,1,1,1,0 (one per cycle) -> rise high exactly one cycle after the first 1 is sampled; fall one cycle after the 0; toggle_cnt=2; last_high_len=3.
3. Hold q_in=1 for 16 samples after entering HIGH -> stuck=1 and state_o=3 after the 16th sample, not the 15th. Then q_in=0 -> fall=1, stuck=0, last_high_len=16, state_o=1.
4. Toggle q_in every cycle for 257 samples from LOW -> toggle_cnt wraps to 1; rise and fall alternate with no gaps; stuck stays 0.
5. In HIGH with run_len=5: en=0 for 10 cycles while q_in goes 0 then 1, then en=1 with q_in=1 -> no pulses, no count change, no stuck. The run continues from 5, reaching stuck after 11 more enabled samples.
6. Assert clr mid-high-pulse with toggle_cnt=7 -> next cycle toggle_cnt=0, last_high_len=0, state_o=0. The next enabled sample re-enters LOW/HIGH with no pulse.
